// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the two-source round-robin arbiter.
package mux_arb_pkg;

  // Identifies which requester a beat came from.
  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  // Channel ownership: nobody, source A, or source B.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/arb_data_mux.sv
// DATA_W-wide 2:1 payload select steered by the arbiter grant.
module arb_data_mux
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  src_e              sel_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic [DATA_W-1:0] y_data_o
);

  // Pass through the payload of whichever source currently holds the grant.
  always_comb begin
    y_data_o = (sel_i == SRC_B) ? b_data_i : a_data_i;
  end

endmodule

// File: rtl/mux_arbiter2.sv
// Round-robin arbiter sharing one registered output channel between sources
// A and B, with a burst limit that bounds how long one owner can hold it.
module mux_arbiter2
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              a_valid_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  output logic              y_valid_o,
  output logic [DATA_W-1:0] y_data_o,
  output logic              y_src_o,
  input  logic              y_ready_i
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  arb_state_e        r_state;
  arb_state_e        w_stateNext;
  logic [CNT_W-1:0]  r_beatCnt;
  logic [CNT_W-1:0]  w_beatCntNext;
  src_e              r_lastSrc;
  logic              r_yValid;
  logic [DATA_W-1:0] r_yData;
  src_e              r_ySrc;

  logic              w_loadEn;
  logic              w_ownerValid;
  logic              w_otherValid;
  src_e              w_ownerSrc;
  logic              w_gntValid;
  src_e              w_gntSrc;
  logic              w_accept;
  logic [DATA_W-1:0] w_muxData;

  // The output register can take a new beat when empty or draining this cycle.
  assign w_loadEn = !r_yValid || y_ready_i;
  assign w_accept = w_gntValid && w_loadEn;

  // Readies are held low while reset is asserted, independent of the grant.
  assign a_ready_o = rst_ni && w_gntValid && (w_gntSrc == SRC_A) && w_loadEn;
  assign b_ready_o = rst_ni && w_gntValid && (w_gntSrc == SRC_B) && w_loadEn;

  assign y_valid_o = r_yValid;
  assign y_data_o  = r_yData;
  assign y_src_o   = r_ySrc;

  arb_data_mux #(
    .DATA_W (DATA_W)
  ) u_dataMux (
    .sel_i    (w_gntSrc),
    .a_data_i (a_data_i),
    .b_data_i (b_data_i),
    .y_data_o (w_muxData)
  );

  // Grant: keep the owner until its burst is spent (unless the other side is idle), then round-robin.
  always_comb begin
    w_ownerValid = 1'b0;
    w_otherValid = 1'b0;
    w_ownerSrc   = SRC_A;
    w_gntValid   = 1'b0;
    w_gntSrc     = SRC_A;
    case (r_state)
      OWN_A: begin
        w_ownerValid = a_valid_i;
        w_otherValid = b_valid_i;
        w_ownerSrc   = SRC_A;
      end
      OWN_B: begin
        w_ownerValid = b_valid_i;
        w_otherValid = a_valid_i;
        w_ownerSrc   = SRC_B;
      end
      default: begin
      end
    endcase
    if ((r_state != IDLE) && w_ownerValid && ((r_beatCnt < MAX_CNT) || !w_otherValid)) begin
      w_gntValid = 1'b1;
      w_gntSrc   = w_ownerSrc;
    end else if (a_valid_i && b_valid_i) begin
      w_gntValid = 1'b1;
      w_gntSrc   = (r_lastSrc == SRC_A) ? SRC_B : SRC_A;
    end else if (a_valid_i) begin
      w_gntValid = 1'b1;
      w_gntSrc   = SRC_A;
    end else if (b_valid_i) begin
      w_gntValid = 1'b1;
      w_gntSrc   = SRC_B;
    end
  end

  // Ownership and burst counting: count on by the owner, restart at 1 on a switch, clear when the owner leaves.
  always_comb begin
    w_stateNext   = r_state;
    w_beatCntNext = r_beatCnt;
    if (w_accept) begin
      if (((w_gntSrc == SRC_A) && (r_state == OWN_A)) ||
          ((w_gntSrc == SRC_B) && (r_state == OWN_B))) begin
        w_beatCntNext = (r_beatCnt == MAX_CNT) ? MAX_CNT : r_beatCnt + CNT_W'(1);
      end else begin
        w_stateNext   = (w_gntSrc == SRC_A) ? OWN_A : OWN_B;
        w_beatCntNext = CNT_W'(1);
      end
    end else if ((r_state != IDLE) && !w_ownerValid) begin
      w_stateNext   = IDLE;
      w_beatCntNext = '0;
    end
  end

  // Ownership state, burst counter and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_beatCnt <= '0;
      r_lastSrc <= SRC_B;
    end else begin
      r_state   <= w_stateNext;
      r_beatCnt <= w_beatCntNext;
      if (w_accept) begin
        r_lastSrc <= w_gntSrc;
      end
    end
  end

  // One-entry output register: load on accept, otherwise empty when the sink takes the beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_yValid <= 1'b0;
      r_yData  <= '0;
      r_ySrc   <= SRC_A;
    end else if (w_accept) begin
      r_yValid <= 1'b1;
      r_yData  <= w_muxData;
      r_ySrc   <= w_gntSrc;
    end else if (y_ready_i) begin
      r_yValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arbiter2.sv
// Directed-vector bench for mux_arbiter2: one burst-4 instance and one burst-1 instance.
module tb_mux_arbiter2;

  logic       clk;
  logic       rst_n;
  logic       aValid, bValid, yReady;
  logic [7:0] aData, bData;
  logic       aReady, bReady, yValid, ySrc;
  logic [7:0] yData;
  logic       aValid1, bValid1, yReady1;
  logic [7:0] aData1, bData1;
  logic       aReady1, bReady1, yValid1, ySrc1;
  logic [7:0] yData1;
  int         checkCnt;
  int         passCnt;

  mux_arbiter2 #(.DATA_W(8), .MAX_BURST(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .a_valid_i(aValid), .a_data_i(aData), .a_ready_o(aReady),
    .b_valid_i(bValid), .b_data_i(bData), .b_ready_o(bReady),
    .y_valid_o(yValid), .y_data_o(yData), .y_src_o(ySrc), .y_ready_i(yReady)
  );

  mux_arbiter2 #(.DATA_W(8), .MAX_BURST(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_valid_i(aValid1), .a_data_i(aData1), .a_ready_o(aReady1),
    .b_valid_i(bValid1), .b_data_i(bData1), .b_ready_o(bReady1),
    .y_valid_o(yValid1), .y_data_o(yData1), .y_src_o(ySrc1), .y_ready_i(yReady1)
  );

  // Free-running 10-time-unit clock; all stimulus changes on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pulse reset with both instances' inputs idle; returns on a falling edge with reset released.
  task automatic doReset();
    rst_n = 1'b0;
    aValid = 0; bValid = 0; aData = 0; bData = 0; yReady = 1;
    aValid1 = 0; bValid1 = 0; aData1 = 0; bData1 = 0; yReady1 = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset values, with requests pending to show readies are forced low.
  task automatic test_reset();
    rst_n = 1'b0;
    aValid = 1; bValid = 1; aData = 8'h12; bData = 8'h34; yReady = 1;
    aValid1 = 0; bValid1 = 0; aData1 = 0; bData1 = 0; yReady1 = 1;
    #3;
    checkCnt++; if (yValid !== 1'b0) $display("[TB] FAIL reset_yvalid: got %b want 0", yValid); else passCnt++;
    checkCnt++; if (yData !== 8'h00) $display("[TB] FAIL reset_ydata: got %h want 00", yData); else passCnt++;
    checkCnt++; if (ySrc !== 1'b0) $display("[TB] FAIL reset_ysrc: got %b want 0", ySrc); else passCnt++;
    checkCnt++; if (aReady !== 1'b0) $display("[TB] FAIL reset_aready: got %b want 0", aReady); else passCnt++;
    checkCnt++; if (bReady !== 1'b0) $display("[TB] FAIL reset_bready: got %b want 0", bReady); else passCnt++;
    doReset();
  endtask

  // A alone streams 11, 22, 33; each appears one cycle after its accept.
  task automatic test_single_source();
    logic [7:0] d;
    yReady = 1;
    aValid = 1;
    for (int i = 0; i < 3; i++) begin
      d = 8'(8'h11 * (i + 1));
      aData = d;
      #1;
      checkCnt++; if (aReady !== 1'b1) $display("[TB] FAIL single_aready%0d: got %b want 1", i, aReady); else passCnt++;
      checkCnt++; if (bReady !== 1'b0) $display("[TB] FAIL single_bready%0d: got %b want 0", i, bReady); else passCnt++;
      @(negedge clk);
      checkCnt++; if (yValid !== 1'b1) $display("[TB] FAIL single_yvalid%0d: got %b want 1", i, yValid); else passCnt++;
      checkCnt++; if (yData !== d) $display("[TB] FAIL single_ydata%0d: got %h want %h", i, yData, d); else passCnt++;
      checkCnt++; if (ySrc !== 1'b0) $display("[TB] FAIL single_ysrc%0d: got %b want 0", i, ySrc); else passCnt++;
    end
    aValid = 0;
    @(negedge clk);
    checkCnt++; if (yValid !== 1'b0) $display("[TB] FAIL single_drain_valid: got %b want 0", yValid); else passCnt++;
    checkCnt++; if (yData !== 8'h33) $display("[TB] FAIL single_drain_hold: got %h want 33", yData); else passCnt++;
  endtask

  // Both sources always valid with burst 4: sources 0x4, 1x4, 0x4, no bubbles.
  task automatic test_fairness();
    int aCnt, bCnt;
    logic e;
    logic [7:0] expData;
    doReset();
    aCnt = 0; bCnt = 0;
    yReady = 1;
    for (int i = 0; i < 12; i++) begin
      e = ((i / 4) % 2) == 1;
      aValid = 1; bValid = 1;
      aData = 8'(8'hA0 + aCnt);
      bData = 8'(8'hB0 + bCnt);
      #1;
      checkCnt++; if (aReady !== !e) $display("[TB] FAIL fair_aready%0d: got %b want %b", i, aReady, !e); else passCnt++;
      checkCnt++; if (bReady !== e) $display("[TB] FAIL fair_bready%0d: got %b want %b", i, bReady, e); else passCnt++;
      expData = e ? bData : aData;
      if (e) bCnt++; else aCnt++;
      @(negedge clk);
      checkCnt++; if (yValid !== 1'b1) $display("[TB] FAIL fair_yvalid%0d: got %b want 1", i, yValid); else passCnt++;
      checkCnt++; if (ySrc !== e) $display("[TB] FAIL fair_ysrc%0d: got %b want %b", i, ySrc, e); else passCnt++;
      checkCnt++; if (yData !== expData) $display("[TB] FAIL fair_ydata%0d: got %h want %h", i, yData, expData); else passCnt++;
    end
    aValid = 0; bValid = 0;
    @(negedge clk);
  endtask

  // Stalled sink holds C3 for 3 cycles; release drains it and loads 3C in the same cycle.
  task automatic test_backpressure();
    doReset();
    yReady = 1; aValid = 1; aData = 8'hC3;
    #1;
    checkCnt++; if (aReady !== 1'b1) $display("[TB] FAIL bp_first_aready: got %b want 1", aReady); else passCnt++;
    @(negedge clk);
    yReady = 0; aData = 8'h3C; bValid = 1; bData = 8'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkCnt++; if (aReady !== 1'b0) $display("[TB] FAIL bp_aready%0d: got %b want 0", i, aReady); else passCnt++;
      checkCnt++; if (bReady !== 1'b0) $display("[TB] FAIL bp_bready%0d: got %b want 0", i, bReady); else passCnt++;
      @(negedge clk);
      checkCnt++; if (yValid !== 1'b1) $display("[TB] FAIL bp_yvalid%0d: got %b want 1", i, yValid); else passCnt++;
      checkCnt++; if (yData !== 8'hC3) $display("[TB] FAIL bp_ydata%0d: got %h want c3", i, yData); else passCnt++;
    end
    yReady = 1;
    #1;
    checkCnt++; if (aReady !== 1'b1) $display("[TB] FAIL bp_release_aready: got %b want 1", aReady); else passCnt++;
    checkCnt++; if (bReady !== 1'b0) $display("[TB] FAIL bp_release_bready: got %b want 0", bReady); else passCnt++;
    @(negedge clk);
    aValid = 0; bValid = 0;
    checkCnt++; if (yValid !== 1'b1) $display("[TB] FAIL bp_reload_valid: got %b want 1", yValid); else passCnt++;
    checkCnt++; if (yData !== 8'h3C) $display("[TB] FAIL bp_reload_data: got %h want 3c", yData); else passCnt++;
    @(negedge clk);
    checkCnt++; if (yValid !== 1'b0) $display("[TB] FAIL bp_empty: got %b want 0", yValid); else passCnt++;
  endtask

  // Burst limit 1 with both sources streaming: A0, B0, A1, B1, ...
  task automatic test_alternation();
    int aCnt, bCnt;
    logic e;
    logic [7:0] expData;
    doReset();
    aCnt = 0; bCnt = 0;
    yReady1 = 1;
    for (int i = 0; i < 6; i++) begin
      e = (i % 2) == 1;
      aValid1 = 1; bValid1 = 1;
      aData1 = 8'(8'hA0 + aCnt);
      bData1 = 8'(8'hB0 + bCnt);
      #1;
      checkCnt++; if (aReady1 !== !e) $display("[TB] FAIL alt_aready%0d: got %b want %b", i, aReady1, !e); else passCnt++;
      checkCnt++; if (bReady1 !== e) $display("[TB] FAIL alt_bready%0d: got %b want %b", i, bReady1, e); else passCnt++;
      expData = e ? bData1 : aData1;
      if (e) bCnt++; else aCnt++;
      @(negedge clk);
      checkCnt++; if (yData1 !== expData) $display("[TB] FAIL alt_ydata%0d: got %h want %h", i, yData1, expData); else passCnt++;
      checkCnt++; if (ySrc1 !== e) $display("[TB] FAIL alt_ysrc%0d: got %b want %b", i, ySrc1, e); else passCnt++;
    end
    aValid1 = 0; bValid1 = 0;
    @(negedge clk);
  endtask

  // A owns for 2 beats then withdraws; B takes over at once with a fresh burst of 4.
  task automatic test_owner_withdrawal();
    logic [6:0] aVec, bVec, expB;
    int aCnt, bCnt;
    logic e;
    logic [7:0] expData;
    doReset();
    aVec = 7'b1111011;
    bVec = 7'b1111100;
    expB = 7'b0111100;
    aCnt = 0; bCnt = 0;
    yReady = 1;
    for (int i = 0; i < 7; i++) begin
      e = expB[i];
      aValid = aVec[i]; bValid = bVec[i];
      aData = 8'(8'h01 + aCnt);
      bData = 8'(8'hB7 + bCnt);
      #1;
      checkCnt++; if (aReady !== !e) $display("[TB] FAIL wd_aready%0d: got %b want %b", i, aReady, !e); else passCnt++;
      checkCnt++; if (bReady !== e) $display("[TB] FAIL wd_bready%0d: got %b want %b", i, bReady, e); else passCnt++;
      expData = e ? bData : aData;
      if (e) bCnt++; else aCnt++;
      @(negedge clk);
      checkCnt++; if (ySrc !== e) $display("[TB] FAIL wd_ysrc%0d: got %b want %b", i, ySrc, e); else passCnt++;
      checkCnt++; if (yData !== expData) $display("[TB] FAIL wd_ydata%0d: got %h want %h", i, yData, expData); else passCnt++;
    end
    aValid = 0; bValid = 0;
    @(negedge clk);
  endtask

  // Reset while 5A from B sits stalled; everything clears at once and A wins first afterwards.
  task automatic test_reset_mid_stream();
    doReset();
    yReady = 1; bValid = 1; bData = 8'h5A;
    @(negedge clk);
    yReady = 0; bData = 8'h77; aValid = 1; aData = 8'h66;
    checkCnt++; if (yData !== 8'h5A) $display("[TB] FAIL rst_mid_pre: got %h want 5a", yData); else passCnt++;
    #2;
    rst_n = 1'b0;
    #1;
    checkCnt++; if (yValid !== 1'b0) $display("[TB] FAIL rst_mid_yvalid: got %b want 0", yValid); else passCnt++;
    checkCnt++; if (yData !== 8'h00) $display("[TB] FAIL rst_mid_ydata: got %h want 00", yData); else passCnt++;
    checkCnt++; if (ySrc !== 1'b0) $display("[TB] FAIL rst_mid_ysrc: got %b want 0", ySrc); else passCnt++;
    checkCnt++; if (aReady !== 1'b0) $display("[TB] FAIL rst_mid_aready: got %b want 0", aReady); else passCnt++;
    checkCnt++; if (bReady !== 1'b0) $display("[TB] FAIL rst_mid_bready: got %b want 0", bReady); else passCnt++;
    @(negedge clk);
    rst_n = 1'b1;
    yReady = 1;
    #1;
    checkCnt++; if (aReady !== 1'b1) $display("[TB] FAIL rst_post_aready: got %b want 1", aReady); else passCnt++;
    checkCnt++; if (bReady !== 1'b0) $display("[TB] FAIL rst_post_bready: got %b want 0", bReady); else passCnt++;
    @(negedge clk);
    aValid = 0; bValid = 0;
    checkCnt++; if (ySrc !== 1'b0) $display("[TB] FAIL rst_post_ysrc: got %b want 0", ySrc); else passCnt++;
    checkCnt++; if (yData !== 8'h66) $display("[TB] FAIL rst_post_ydata: got %h want 66", yData); else passCnt++;
    @(negedge clk);
  endtask

  // Run every scenario in order, then report.
  initial begin
    checkCnt = 0;
    passCnt  = 0;
    test_reset();
    test_single_source();
    test_fairness();
    test_backpressure();
    test_alternation();
    test_owner_withdrawal();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
